param_regfile_sb: RTL and testbench

//  Parametrised register file for the 5-stage pipeline: WIDTH-bit x DEPTH storage, one synchronous

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_row.sv | 47 ++++
 rtl/param_regfile_sb.sv | 120 ++++++++++++
 tb/tb_param_regfile_sb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register file and the pipeline stages around it
//   (decode reads operands through it, writeback writes results through it).
//
//   RF_WIDTH   default data bits per register
//   RF_DEPTH   default number of registers (power of two, >= 2)
//   RF_AW      register index width derived from RF_DEPTH
//   reg_addr_t register index type at the default depth
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_WIDTH = 16;
   localparam int RF_DEPTH = 16;
   localparam int RF_AW    = $clog2(RF_DEPTH);

   typedef logic [RF_AW-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_row.sv
// -----------------------------------------------------------------------------
// regfile_row
//   One register of the register file together with its scoreboard busy bit.
//
//   Ports
//     clk      in   1      rising-edge clock
//     rst      in   1      asynchronous active-low reset (clears q and busy)
//     wr_hit   in   1      write this row on the next edge; also retires the
//                          pending producer (clears busy)
//     set_hit  in   1      an instruction that will write this row has issued
//     d        in   WIDTH  data to store when wr_hit is high
//     q        out  WIDTH  stored value
//     busy     out  1      row has a pending producer
// -----------------------------------------------------------------------------
module regfile_row
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_hit,
   input  logic             set_hit,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             busy
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q    <= '0;
         busy <= 1'b0;
      end else begin
         if (wr_hit) begin
            q <= d;
         end
         // A newly issued producer supersedes the one retiring this cycle,
         // so set takes priority over the writeback clear.
         if (set_hit) begin
            busy <= 1'b1;
         end else if (wr_hit) begin
            busy <= 1'b0;
         end
      end
   end

endmodule : regfile_row

// File: rtl/param_regfile_sb.sv
// -----------------------------------------------------------------------------
// param_regfile_sb
//   WIDTH x DEPTH register file for the 5-stage pipeline: one synchronous
//   write port, two combinational read ports with write-to-read bypass, and a
//   per-register busy scoreboard used by decode for hazard detection.
//   Read ports are plain muxes gated by their enables (no tristate bitlines).
//
//   Build option
//     REGFILE_ZERO_REG_EN  when defined, register 0 is hardwired to zero:
//                          writes and scoreboard sets to index 0 are dropped,
//                          and reads of index 0 return data 0, busy 0 with no
//                          bypass. When undefined, register 0 is ordinary.
//
//   Ports
//     clk       in   1      rising-edge clock
//     rst       in   1      asynchronous active-low reset
//     wr_en     in   1      write strobe
//     wr_addr   in   AW     write register index
//     wr_data   in   WIDTH  write data
//     rd_en1    in   1      read port 1 enable (outputs forced to 0 when low)
//     rd_addr1  in   AW     read port 1 index
//     rd_data1  out  WIDTH  read port 1 data
//     rd_busy1  out  1      rd_addr1 has a pending producer
//     rd_en2    in   1      read port 2 enable (outputs forced to 0 when low)
//     rd_addr2  in   AW     read port 2 index
//     rd_data2  out  WIDTH  read port 2 data
//     rd_busy2  out  1      rd_addr2 has a pending producer
//     sb_set    in   1      mark sb_addr busy from the next edge on
//     sb_addr   in   AW     register to mark busy
// -----------------------------------------------------------------------------
module param_regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en1,
   input  logic [AW-1:0]    rd_addr1,
   output logic [WIDTH-1:0] rd_data1,
   output logic             rd_busy1,
   input  logic             rd_en2,
   input  logic [AW-1:0]    rd_addr2,
   output logic [WIDTH-1:0] rd_data2,
   output logic             rd_busy2,
   input  logic             sb_set,
   input  logic [AW-1:0]    sb_addr
);

   logic [WIDTH-1:0] row_q [DEPTH];
   logic [DEPTH-1:0] row_busy;

   // Effective write / set strobes. With a hardwired zero register, any
   // access aimed at index 0 is dropped here, so row 0 keeps its reset state
   // (data 0, busy 0) forever and the bypass below never forwards to it.
   logic wr_ok;
   logic set_ok;

`ifdef REGFILE_ZERO_REG_EN
   assign wr_ok  = wr_en  && (wr_addr != '0);
   assign set_ok = sb_set && (sb_addr != '0);
`else
   assign wr_ok  = wr_en;
   assign set_ok = sb_set;
`endif

   // Storage rows
   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      logic wr_hit;
      logic set_hit;

      assign wr_hit  = wr_ok  && (wr_addr == AW'(g));
      assign set_hit = set_ok && (sb_addr == AW'(g));

      regfile_row #(
         .WIDTH (WIDTH)
      ) u_row (
         .clk     (clk),
         .rst     (rst),
         .wr_hit  (wr_hit),
         .set_hit (set_hit),
         .d       (wr_data),
         .q       (row_q[g]),
         .busy    (row_busy[g])
      );
   end

   // Read ports: a same-cycle write to the addressed register is forwarded
   // (write-before-read) and also hides the busy bit it is about to clear.
   // A same-cycle sb_set is deliberately not forwarded; it shows up next cycle.
   logic hit1;
   logic hit2;

   assign hit1 = wr_ok && (wr_addr == rd_addr1);
   assign hit2 = wr_ok && (wr_addr == rd_addr2);

   always_comb begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
      if (rd_en1) begin
         rd_data1 = hit1 ? wr_data : row_q[rd_addr1];
         rd_busy1 = row_busy[rd_addr1] & ~hit1;
      end
   end

   always_comb begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
      if (rd_en2) begin
         rd_data2 = hit2 ? wr_data : row_q[rd_addr2];
         rd_busy2 = row_busy[rd_addr2] & ~hit2;
      end
   end

endmodule : param_regfile_sb

// File: tb/tb_param_regfile_sb.sv
module tb_param_regfile_sb;
   import regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wr_en;
   reg_addr_t   wr_addr;
   logic [15:0] wr_data;
   logic        rd_en1;
   reg_addr_t   rd_addr1;
   logic [15:0] rd_data1;
   logic        rd_busy1;
   logic        rd_en2;
   reg_addr_t   rd_addr2;
   logic [15:0] rd_data2;
   logic        rd_busy2;
   logic        sb_set;
   reg_addr_t   sb_addr;

   int n_tests;
   int n_fail;

   param_regfile_sb dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en1   (rd_en1),
      .rd_addr1 (rd_addr1),
      .rd_data1 (rd_data1),
      .rd_busy1 (rd_busy1),
      .rd_en2   (rd_en2),
      .rd_addr2 (rd_addr2),
      .rd_data2 (rd_data2),
      .rd_busy2 (rd_busy2),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: architectural register contents and busy flags.
   logic [15:0] m_data [16];
   bit          m_busy [16];

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_data[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [15:0] m_rd_data(bit en, int a);
      if (!en) return '0;
      if (ZERO && a == 0) return '0;
      if (wr_en && int'(wr_addr) == a) return wr_data;
      return m_data[a];
   endfunction

   function automatic bit m_rd_busy(bit en, int a);
      if (!en) return 1'b0;
      if (ZERO && a == 0) return 1'b0;
      if (wr_en && int'(wr_addr) == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_edge();
      if (wr_en && !(ZERO && wr_addr == 0)) begin
         m_data[wr_addr] = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (sb_set && !(ZERO && sb_addr == 0)) m_busy[sb_addr] = 1'b1;
   endtask

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit we, int wa, logic [15:0] wd, bit re1, int ra1,
                        bit re2, int ra2, bit ss, int sa);
      wr_en    = we;
      wr_addr  = reg_addr_t'(wa);
      wr_data  = wd;
      rd_en1   = re1;
      rd_addr1 = reg_addr_t'(ra1);
      rd_en2   = re2;
      rd_addr2 = reg_addr_t'(ra2);
      sb_set   = ss;
      sb_addr  = reg_addr_t'(sa);
   endtask

   task automatic idle();
      drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance one clock: the model follows the edge, inputs change on negedge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_model(string name);
      check({name, ".d1"}, rd_data1, m_rd_data(rd_en1, int'(rd_addr1)));
      check({name, ".b1"}, 16'(rd_busy1), 16'(m_rd_busy(rd_en1, int'(rd_addr1))));
      check({name, ".d2"}, rd_data2, m_rd_data(rd_en2, int'(rd_addr2)));
      check({name, ".b2"}, 16'(rd_busy2), 16'(m_rd_busy(rd_en2, int'(rd_addr2))));
   endtask

   typedef struct {
      bit          we;
      int          wa;
      logic [15:0] wd;
      bit          re1;
      int          ra1;
      bit          re2;
      int          ra2;
      bit          ss;
      int          sa;
      logic [15:0] e_d1;
      bit          e_b1;
      logic [15:0] e_d2;
      bit          e_b2;
   } vec_t;

   function automatic vec_t mk(bit we, int wa, logic [15:0] wd, bit re1, int ra1,
                               bit re2, int ra2, bit ss, int sa,
                               logic [15:0] e_d1, bit e_b1, logic [15:0] e_d2, bit e_b2);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.re1 = re1; v.ra1 = ra1;
      v.re2 = re2; v.ra2 = ra2; v.ss = ss; v.sa = sa;
      v.e_d1 = e_d1; v.e_b1 = e_b1; v.e_d2 = e_d2; v.e_b2 = e_b2;
      return v;
   endfunction

   vec_t vecs [$];

   initial begin
      logic [15:0] e0d;
      logic        e0b;
      n_tests = 0;
      n_fail  = 0;

      //         we wa wd        re1 ra1 re2 ra2 ss sa   d1       b1 d2       b2
      vecs.push_back(mk(1, 5, 16'hBEEF, 1, 5, 1, 5, 0, 0,  16'hBEEF, 0, 16'hBEEF, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 5, 1, 5, 0, 0,  16'hBEEF, 0, 16'hBEEF, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 5, 1, 5, 0, 0,  16'h0000, 0, 16'hBEEF, 0));
      vecs.push_back(mk(1, 3, 16'h1111, 1, 3, 1, 5, 0, 0,  16'h1111, 0, 16'hBEEF, 0));
      vecs.push_back(mk(1, 3, 16'h2222, 1, 3, 1, 3, 0, 0,  16'h2222, 0, 16'h2222, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 5, 1, 3, 0, 0,  16'hBEEF, 0, 16'h2222, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 1, 3, 1, 7,  16'h0000, 0, 16'h2222, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 1, 7, 0, 0,  16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(1, 7, 16'h0077, 1, 7, 0, 7, 0, 0,  16'h0077, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 1, 7, 0, 0,  16'h0077, 0, 16'h0077, 0));
      vecs.push_back(mk(1, 7, 16'h0088, 1, 7, 1, 5, 1, 7,  16'h0088, 0, 16'hBEEF, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 1, 7, 0, 0,  16'h0088, 1, 16'h0088, 1));
      vecs.push_back(mk(1, 7, 16'h0099, 1, 7, 1, 7, 0, 0,  16'h0099, 0, 16'h0099, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 7, 0, 0,  16'h0099, 0, 16'h0000, 0));

      // Reset held, outputs read 0 even with enables high
      rst = 1'b0;
      drive(0, 0, 16'h0, 1, 2, 1, 4, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_hold.d1", rd_data1, 16'h0);
      check("rst_hold.d2", rd_data2, 16'h0);
      rst = 1'b1;
      @(negedge clk);

      // Every index reads 0/0 after reset
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 16'h0, 1, i, 1, 15 - i, 0, 0);
         #1;
         check($sformatf("reset_r%0d.d1", i), rd_data1, 16'h0);
         check($sformatf("reset_r%0d.b1", i), 16'(rd_busy1), 16'h0);
         check($sformatf("reset_r%0d.d2", i), rd_data2, 16'h0);
         check($sformatf("reset_r%0d.b2", i), 16'(rd_busy2), 16'h0);
         tick();
      end

      // Directed table: write/read, enables, bypass, scoreboard
      foreach (vecs[k]) begin
         drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].re1, vecs[k].ra1,
               vecs[k].re2, vecs[k].ra2, vecs[k].ss, vecs[k].sa);
         #1;
         check($sformatf("vec%0d.d1", k), rd_data1, vecs[k].e_d1);
         check($sformatf("vec%0d.b1", k), 16'(rd_busy1), 16'(vecs[k].e_b1));
         check($sformatf("vec%0d.d2", k), rd_data2, vecs[k].e_d2);
         check($sformatf("vec%0d.b2", k), 16'(rd_busy2), 16'(vecs[k].e_b2));
         tick();
      end

      // Register 0: write all-ones and mark busy in the same cycle
      e0d = ZERO ? 16'h0000 : 16'hFFFF;
      drive(1, 0, 16'hFFFF, 1, 0, 1, 0, 1, 0);
      #1;
      check("r0_same.d1", rd_data1, e0d);
      check("r0_same.b1", 16'(rd_busy1), 16'h0);
      check("r0_same.d2", rd_data2, e0d);
      tick();
      e0b = ZERO ? 1'b0 : 1'b1;
      drive(0, 0, 16'h0, 1, 0, 1, 0, 0, 0);
      #1;
      check("r0_next.d1", rd_data1, e0d);
      check("r0_next.b1", 16'(rd_busy1), 16'(e0b));
      check("r0_next.d2", rd_data2, e0d);
      check("r0_next.b2", 16'(rd_busy2), 16'(e0b));
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), 16'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15),
               $urandom_range(0, 2) == 0, $urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) rd_addr2 = rd_addr1;
         if ($urandom_range(0, 7) == 0) wr_addr = rd_addr1;
         #1;
         check_model($sformatf("rand%0d", n));
         tick();
      end

      // Async reset between edges after r9 written and r4 marked busy
      drive(1, 9, 16'h00AA, 0, 0, 0, 0, 1, 4);
      tick();
      drive(0, 0, 16'h0, 1, 9, 1, 4, 0, 0);
      #1;
      check("pre_rst.d1", rd_data1, 16'h00AA);
      check("pre_rst.b2", 16'(rd_busy2), 16'h1);
      #1;
      rst = 1'b0;
      #1;
      check("async_rst.d1", rd_data1, 16'h0);
      check("async_rst.b2", 16'(rd_busy2), 16'h0);
      rst = 1'b1;
      model_reset();
      @(negedge clk);

      // Reset asserted across an edge with a write pending: write is lost
      drive(1, 9, 16'h0055, 0, 0, 0, 0, 1, 9);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      drive(0, 0, 16'h0, 1, 9, 1, 9, 0, 0);
      #1;
      check("rst_write.d1", rd_data1, 16'h0);
      check("rst_write.b1", 16'(rd_busy1), 16'h0);
      check_model("post_rst");
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_param_regfile_sb
